wave_seq_ctrl: RTL and testbench
================================

# wave_seq_ctrl

Playback controller for the pig signature waveform. Sequences the wave ROM address stream (`sig_addr`) in single-shot, continuous-loop or counted-burst mode, with start/stop control and programmable idle gaps between frames. Sits between the freq_divider `freq_2` output and the wave ROM, replacing a free-running address counter with a commanded, framed sequence.

## Interface
Parameters:
- `ADDR_W`, 4: ROM address width; frame length is `2**ADDR_W` samples.
- `BURST_W`, 4: width of the burst frame count.
- `GAP_W`, 4: width of the inter-frame gap length.

Ports:
- `clk_freq2` in, 1: single clock, `freq_2` from freq_divider; all logic on its rising edge.
- `rst_n_key0` in, 1: reset from key0, **synchronous, active-low**.
- `start` in, 1: start request; level sampled each cycle, acted on only in IDLE.
- `stop` in, 1: abort request; acted on in PLAY and GAP.
- `mode` in, 2: 0 = single, 1 = loop, 2 = burst, 3 = reserved (treated as single).
- `burst_len` in, BURST_W: frames per burst; 0 is treated as 1.
- `gap_len` in, GAP_W: idle cycles between frames in loop/burst; 0 = back-to-back.
- `sig_addr` out, ADDR_W: wave ROM address.
- `rom_en` out, 1: high while `sig_addr` is a valid sample.
- `busy` out, 1: high in PLAY, GAP and DONE.
- `done` out, 1: one-cycle pulse on normal completion.
- `frame_cnt` out, BURST_W: frames completed in the current run, saturating.

## Operation
- States: IDLE, PLAY, GAP, DONE.
- IDLE: `sig_addr`=0, `rom_en`=0. If `start`=1 and `stop`=0, latch `mode`, `burst_len`, `gap_len`, clear `frame_cnt`, then go to PLAY.
- PLAY: `rom_en`=1. `sig_addr` increments by 1 per cycle, modulo `2**ADDR_W`. On the last address (all ones), the frame ends and `frame_cnt` increments, saturating at all ones:
  - single: go to DONE.
  - burst: go to DONE if this was frame `burst_len`; otherwise continue as loop.
  - loop: if the latched gap is 0, wrap to address 0 and stay in PLAY; otherwise go to GAP.
- GAP: `rom_en`=0, `sig_addr`=0. Counts the latched `gap_len` cycles, then returns to PLAY at address 0.
- DONE: `done`=1 for exactly one cycle, `rom_en`=0, then IDLE.
- `stop` in PLAY or GAP: go to IDLE next cycle; `sig_addr`→0; no `done` pulse; `frame_cnt` holds.
- `start` outside IDLE is ignored. In IDLE, `stop` and `start` together: `stop` wins and the block stays IDLE.
- Input changes to `mode`, `burst_len` or `gap_len` during a run have no effect until the next start.

## Timing
- Reset (synchronous on `rst_n_key0`=0): state IDLE; `sig_addr`=0, `rom_en`=0, `busy`=0, `done`=0, `frame_cnt`=0.
- Reset asserted mid-run takes effect at the next edge, overriding all inputs.
- Start latency: `start` sampled at edge t gives PLAY with `sig_addr`=0 and `rom_en`=1 from t+1.
- Single frame (`ADDR_W`=4): addresses 0..15 on cycles t+1..t+16; `done` high at t+17; IDLE at t+18.
- Gap G>0: the last sample is followed by exactly G cycles with `rom_en`=0, then address 0.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `WAVE_SEQ_REVERSE_EN`: when defined, adds input `dir` (1 bit), latched at start.
  - `dir`=1: each frame runs from all ones down to 0 and ends at address 0.
  - In GAP and IDLE, `sig_addr` holds the frame's first address.
- Without the macro: no `dir` port; ascending order only.

## Structure
- Shared package `wave_pkg`: state enum (IDLE/PLAY/GAP/DONE), mode constants `MODE_SINGLE`, `MODE_LOOP`, `MODE_BURST`, and default widths.
- One sub-module, `wave_addr_gen`: address counter with clear, enable, last-address flag and optional direction.
- The FSM, gap counter and frame counter stay in `wave_seq_ctrl`.

## Test plan
- Single mode, start pulse at cycle 5 → `sig_addr` 0..15 on cycles 6..21; `done` only at 22; `busy` high cycles 6..22; `frame_cnt`=1.
- Burst mode, `burst_len`=3, `gap_len`=2 → 3 frames of 16 samples, each separated by 2 `rom_en`=0 cycles; one `done`; `frame_cnt`=3; 52 busy cycles before DONE.
- Loop mode, `gap_len`=0 → address 15 followed directly by 0 with `rom_en` continuously high; `stop` at address 7 → IDLE next cycle, `sig_addr`=0, no `done`.
- `burst_len`=0 → exactly one frame then `done`; `start` held high throughout the run → no restart until the block is back in IDLE.
- `rst_n_key0` low for one cycle at address 9 of a loop → next cycle all outputs at reset values; `start` and `stop` together in IDLE → stays IDLE.
- With `WAVE_SEQ_REVERSE_EN` and `dir`=1 → addresses 15..0, then `done`.

Source files
------------

// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared FSM states, mode codes and default widths for the wave sequencer
package wave_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } wave_state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_LOOP   = 2'd1;
  localparam logic [1:0] MODE_BURST  = 2'd2;

  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_BURST_W = 4;
  localparam int DEF_GAP_W   = 4;
endpackage

// File: rtl/wave_addr_gen.sv
// rtl/wave_addr_gen.sv - wave ROM address counter with load-to-first, step, direction and last flag
module wave_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_dir,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  localparam logic [ADDR_W-1:0] ONE = 1;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_first;

  // A descending frame starts at all ones and ends at zero; wrap is the natural modulo.
  assign w_first = i_dir ? '1 : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= w_first;
    end else if (i_step) begin
      r_addr <= i_dir ? (r_addr - ONE) : (r_addr + ONE);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_addr == ~w_first);
endmodule

// File: rtl/wave_seq_ctrl.sv
// rtl/wave_seq_ctrl.sv - framed single/loop/burst playback sequencer for the wave ROM address
// Optional WAVE_SEQ_REVERSE_EN adds a dir input for descending frames.
module wave_seq_ctrl
  import wave_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic               clk_freq2,
  input  logic               rst_n_key0,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [GAP_W-1:0]   gap_len,
`ifdef WAVE_SEQ_REVERSE_EN
  input  logic               dir,
`endif
  output logic [ADDR_W-1:0]  sig_addr,
  output logic               rom_en,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] frame_cnt
);
  localparam logic [BURST_W-1:0] BURST_ONE = 1;
  localparam logic [GAP_W-1:0]   GAP_ONE   = 1;

  wave_state_t        r_state;
  wave_state_t        w_next;
  logic [1:0]         r_mode;
  logic [BURST_W-1:0] r_burst_len;
  logic [GAP_W-1:0]   r_gap_len;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [BURST_W-1:0] r_frame_cnt;
  logic               r_rom_en;
  logic               r_busy;
  logic               r_done;
  logic               w_start_ok;
  logic               w_addr_last;
  logic               w_last_frame;
  logic               w_step;
  logic               w_dir;
  logic [BURST_W-1:0] w_frame_inc;

  assign w_start_ok  = start & ~stop;
  assign w_frame_inc = (r_frame_cnt == '1) ? r_frame_cnt : (r_frame_cnt + BURST_ONE);
  // Reserved mode 3 falls through to single-shot behaviour.
  assign w_last_frame = (r_mode == MODE_BURST) ? (w_frame_inc == r_burst_len)
                                               : (r_mode != MODE_LOOP);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_next = ST_PLAY;
      ST_PLAY: begin
        if (stop) begin
          w_next = ST_IDLE;
        end else if (w_addr_last) begin
          if (w_last_frame)            w_next = ST_DONE;
          else if (r_gap_len != '0)    w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (stop)                      w_next = ST_IDLE;
        else if (r_gap_cnt == '0)      w_next = ST_PLAY;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_step = (r_state == ST_PLAY) && (w_next == ST_PLAY);

`ifdef WAVE_SEQ_REVERSE_EN
  logic r_dir;
  assign w_dir = ((r_state == ST_IDLE) && w_start_ok) ? dir : r_dir;
  always_ff @(posedge clk_freq2) begin
    if (!rst_n_key0)                          r_dir <= 1'b0;
    else if ((r_state == ST_IDLE) && w_start_ok) r_dir <= dir;
  end
`else
  assign w_dir = 1'b0;
`endif

  always_ff @(posedge clk_freq2) begin
    if (!rst_n_key0) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  // Outputs are registered from the next state so they line up with the address register.
  always_ff @(posedge clk_freq2) begin
    if (!rst_n_key0) begin
      r_mode      <= MODE_SINGLE;
      r_burst_len <= BURST_ONE;
      r_gap_len   <= '0;
      r_gap_cnt   <= '0;
      r_frame_cnt <= '0;
      r_rom_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rom_en <= (w_next == ST_PLAY);
      r_busy   <= (w_next != ST_IDLE);
      r_done   <= (w_next == ST_DONE);
      if ((r_state == ST_IDLE) && w_start_ok) begin
        r_mode      <= mode;
        r_burst_len <= (burst_len == '0) ? BURST_ONE : burst_len;
        r_gap_len   <= gap_len;
        r_frame_cnt <= '0;
      end
      if ((r_state == ST_PLAY) && !stop && w_addr_last) r_frame_cnt <= w_frame_inc;
      if ((r_state == ST_PLAY) && (w_next == ST_GAP))   r_gap_cnt <= r_gap_len - GAP_ONE;
      else if (r_state == ST_GAP)                       r_gap_cnt <= r_gap_cnt - GAP_ONE;
    end
  end

  wave_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk_freq2),
    .rst_n  (rst_n_key0),
    .i_load (!w_step),
    .i_step (w_step),
    .i_dir  (w_dir),
    .o_addr (sig_addr),
    .o_last (w_addr_last)
  );

  assign rom_en    = r_rom_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb/tb_wave_seq_ctrl.sv - randomized self-checking bench for wave_seq_ctrl against a trace model
module tb_wave_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n_key0;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] burst_len;
  logic [3:0] gap_len;
`ifdef WAVE_SEQ_REVERSE_EN
  logic       dir;
`endif
  logic [3:0] sig_addr;
  logic       rom_en;
  logic       busy;
  logic       done;
  logic [3:0] frame_cnt;

  always #5 clk = ~clk;

  wave_seq_ctrl dut (
    .clk_freq2  (clk),
    .rst_n_key0 (rst_n_key0),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
`ifdef WAVE_SEQ_REVERSE_EN
    .dir        (dir),
`endif
    .sig_addr   (sig_addr),
    .rom_en     (rom_en),
    .busy       (busy),
    .done       (done),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    int addr;
    int en;
    int busy;
    int done;
    int fcnt;
  } exp_t;

  exp_t q[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected per-cycle outputs after the start edge, written as a list of frames and gaps.
  task automatic build(input int m, input int bl, input int g, input int d,
                       input int abort_at, input bit abort_rst);
    int   nfr;
    int   first;
    exp_t e;
    q.delete();
    first = d ? 15 : 0;
    nfr = (m == 1) ? 3 : (m == 2) ? ((bl == 0) ? 1 : bl) : 1;
    for (int f = 0; f < nfr; f++) begin
      for (int a = 0; a < 16; a++) q.push_back(exp_t'{(d ? 15 - a : a), 1, 1, 0, f});
      if (f < nfr - 1 || m == 1)
        for (int k = 0; k < g; k++) q.push_back(exp_t'{first, 0, 1, 0, f + 1});
    end
    if (m != 1) q.push_back(exp_t'{first, 0, 1, 1, nfr});
    if (abort_at >= 0 && abort_at < q.size()) begin
      e = q[abort_at];
      q = q[0:abort_at];
      if (abort_rst) q.push_back(exp_t'{0, 0, 0, 0, 0});
      else           q.push_back(exp_t'{first, 0, 0, 0, e.fcnt});
    end else begin
      q.push_back(exp_t'{first, 0, 0, 0, nfr});
    end
  endtask

  task automatic run(input string nm, input int m, input int bl, input int g, input int d,
                     input int abort_at, input bit abort_rst, input bit hold_start);
    build(m, bl, g, d, abort_at, abort_rst);
    @(negedge clk);
    mode = 2'(m); burst_len = 4'(bl); gap_len = 4'(g);
    start = 1'b1; stop = 1'b0; rst_n_key0 = 1'b1;
`ifdef WAVE_SEQ_REVERSE_EN
    dir = d[0];
`endif
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      check_val({nm, " addr"},  sig_addr,  q[i].addr);
      check_val({nm, " rom_en"}, rom_en,   q[i].en);
      check_val({nm, " busy"},  busy,      q[i].busy);
      check_val({nm, " done"},  done,      q[i].done);
      check_val({nm, " frame_cnt"}, frame_cnt, q[i].fcnt);
      start      = hold_start && (i < q.size() - 1);
      stop       = (i == abort_at) && !abort_rst;
      rst_n_key0 = !((i == abort_at) && abort_rst);
      mode       = 2'($urandom);
      burst_len  = 4'($urandom);
      gap_len    = 4'($urandom);
`ifdef WAVE_SEQ_REVERSE_EN
      dir        = 1'($urandom);
`endif
    end
    start = 1'b0; stop = 1'b0; rst_n_key0 = 1'b1;
    repeat (2) @(negedge clk);
    check_val({nm, " idle busy"}, busy, 0);
    check_val({nm, " idle rom_en"}, rom_en, 0);
  endtask

  initial begin
    int m, bl, g, d, ab;
    bit ar;
    rst_n_key0 = 1'b0; start = 1'b0; stop = 1'b0;
    mode = 2'd0; burst_len = 4'd0; gap_len = 4'd0;
`ifdef WAVE_SEQ_REVERSE_EN
    dir = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_val("reset addr", sig_addr, 0);
    check_val("reset rom_en", rom_en, 0);
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset frame_cnt", frame_cnt, 0);
    rst_n_key0 = 1'b1;
    repeat (2) @(negedge clk);

    run("single", 0, 0, 0, 0, -1, 1'b0, 1'b0);
    run("burst3gap2", 2, 3, 2, 0, -1, 1'b0, 1'b0);
    run("loop stop7", 1, 0, 0, 0, 7, 1'b0, 1'b0);
    run("burst0 hold", 2, 0, 1, 0, -1, 1'b0, 1'b1);
    run("loop rst9", 1, 5, 1, 0, 9, 1'b1, 1'b0);
    run("mode3", 3, 7, 3, 0, -1, 1'b0, 1'b0);
    run("burst stop last", 2, 2, 0, 0, 15, 1'b0, 1'b0);

    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("start+stop busy", busy, 0);
      check_val("start+stop rom_en", rom_en, 0);
    end
    start = 1'b0; stop = 1'b0;

`ifdef WAVE_SEQ_REVERSE_EN
    run("reverse single", 0, 0, 0, 1, -1, 1'b0, 1'b0);
    run("reverse burst", 2, 2, 1, 1, -1, 1'b0, 1'b0);
`endif

    for (int r = 0; r < 20; r++) begin
      m  = int'($urandom_range(0, 3));
      bl = int'($urandom_range(0, 4));
      g  = int'($urandom_range(0, 3));
      d  = 0;
`ifdef WAVE_SEQ_REVERSE_EN
      d  = int'($urandom_range(0, 1));
`endif
      build(m, bl, g, d, -1, 1'b0);
      ab = -1;
      if (m == 1 || $urandom_range(0, 9) < 3) ab = int'($urandom_range(0, q.size() - 2));
      ar = ($urandom_range(0, 3) == 0);
      run("random", m, bl, g, d, ab, ar, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
